// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
//   master : fetch unit  (drives req_valid/req_addr/rsp_ready)
//   slave  : memory      (drives req_ready/rsp_valid/rsp_data/rsp_err)
interface inst_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic              imem_rsp_ready;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              imem_rsp_err;

  modport master (
    output imem_req_valid, imem_req_addr, imem_rsp_ready,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, imem_rsp_ready,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: holds the fetch PC, issues one word read at a time
// over the imem bus and hands {inst, pc} to the core with valid/ready.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   imem            imem request/response bus (master side)
//   i_dnpc          next PC from the core, taken on the output handshake
//   i_flush         redirect to i_flush_pc (beats everything but reset)
//   i_flush_pc      redirect target
//   o_out_valid     {o_out_inst, o_out_pc} valid, i_out_ready consumes
//   o_fetch_err     qualifies o_out_valid: misaligned PC or bus error
module inst_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_unit_if.master   imem,
  input  logic [ADDR_W-1:0]   i_dnpc,
  input  logic                i_flush,
  input  logic [ADDR_W-1:0]   i_flush_pc,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [DATA_W-1:0]   o_out_inst,
  output logic [ADDR_W-1:0]   o_out_pc,
  output logic                o_fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_DROP
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_out_pc, w_out_pc_nxt;
  logic [DATA_W-1:0] r_out_inst, w_out_inst_nxt;
  logic              r_fetch_err, w_fetch_err_nxt;
  logic              r_req_valid, r_rsp_ready, r_out_valid;
  logic              w_misaligned, w_req_fire, w_out_fire;

  assign w_misaligned = (r_pc[1:0] != 2'b00);
  assign w_req_fire   = r_req_valid && imem.imem_req_ready;
  assign w_out_fire   = r_out_valid && i_out_ready;

  // Next-state and next-datapath decode
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_out_pc_nxt    = r_out_pc;
    w_out_inst_nxt  = r_out_inst;
    w_fetch_err_nxt = r_fetch_err;

    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_misaligned) begin
          // Misaligned PC never reaches the bus; report it as a faulting fetch
          w_out_inst_nxt  = '0;
          w_out_pc_nxt    = r_pc;
          w_fetch_err_nxt = 1'b1;
          w_state_nxt     = S_VALID;
        end else if (w_req_fire) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rsp_valid) begin
          w_out_inst_nxt  = imem.imem_rsp_data;
          w_out_pc_nxt    = r_pc;
          w_fetch_err_nxt = imem.imem_rsp_err;
          w_state_nxt     = S_VALID;
        end
      end
      S_VALID: begin
        if (w_out_fire) begin
          w_pc_nxt        = i_dnpc;
          w_fetch_err_nxt = 1'b0;
          w_state_nxt     = S_REQ;
        end
      end
      S_DROP: begin
        if (imem.imem_rsp_valid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Redirect: any in-flight request must still drain its response via DROP
    if (i_flush) begin
      w_pc_nxt        = i_flush_pc;
      w_fetch_err_nxt = 1'b0;
      w_out_inst_nxt  = r_out_inst;
      w_out_pc_nxt    = r_out_pc;
      case (r_state)
        S_REQ:          w_state_nxt = w_req_fire ? S_DROP : S_REQ;
        S_WAIT, S_DROP: w_state_nxt = imem.imem_rsp_valid ? S_REQ : S_DROP;
        default:        w_state_nxt = S_REQ;
      endcase
    end
  end

  // State and output registers; bus strobes are precomputed from next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_out_pc    <= '0;
      r_out_inst  <= '0;
      r_fetch_err <= 1'b0;
      r_req_valid <= 1'b0;
      r_rsp_ready <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_out_inst  <= w_out_inst_nxt;
      r_fetch_err <= w_fetch_err_nxt;
      r_req_valid <= (w_state_nxt == S_REQ) && (w_pc_nxt[1:0] == 2'b00);
      r_rsp_ready <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_DROP);
      r_out_valid <= (w_state_nxt == S_VALID);
    end
  end

  assign imem.imem_req_valid = r_req_valid;
  assign imem.imem_req_addr  = r_pc;
  assign imem.imem_rsp_ready = r_rsp_ready;
  assign o_out_valid         = r_out_valid;
  assign o_out_inst          = r_out_inst;
  assign o_out_pc            = r_out_pc;
  assign o_fetch_err         = r_fetch_err;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] dnpc = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        fetch_err;

  always #5 clk = ~clk;

  inst_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  inst_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (bus),
    .i_dnpc     (dnpc),
    .i_flush    (flush),
    .i_flush_pc (flush_pc),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_inst (out_inst),
    .o_out_pc   (out_pc),
    .o_fetch_err(fetch_err)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   fires = 0;

  // Memory contents and bus-error map
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == RESET_PC) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a[15:12] == 4'hE);
  endfunction

  // What the core should see for a fetch from address a
  function automatic exp_t expect_for(input logic [31:0] a);
    exp_t e;
    e.pc = a;
    if (a[1:0] != 2'b00) begin
      e.inst = '0;
      e.err  = 1'b1;
    end else begin
      e.inst = mem_data(a);
      e.err  = mem_err(a);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Knobs and one-shot overrides
  int          k_req_pct = 100, k_out_pct = 100, k_flush_pct = 0, k_lat = 0;
  int          k_jump_pct = 0, k_mis_pct = 0;
  logic        f_flush = 1'b0;
  logic [31:0] f_flush_pc = '0;
  logic        f_dnpc_en = 1'b0;
  logic [31:0] f_dnpc = '0;

  // Reference model state
  logic [31:0] cur_pc = RESET_PC;
  logic        pending = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_delay = 0;
  int          late_cnt = 0;

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
    if ($urandom_range(99) < k_mis_pct) a[1:0] = 2'($urandom_range(3, 1));
    return a;
  endfunction

  task automatic model_reset();
    q.delete();
    cur_pc = RESET_PC;
    q.push_back(expect_for(RESET_PC));
    if (pending) late_cnt = 3;
    pending = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive all inputs for the next edge and advance the reference model
  task automatic step();
    logic rsp_fire;
    if (!rst) begin
      model_reset();
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = $urandom;
      bus.imem_rsp_err   = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      return;
    end
    out_ready = ($urandom_range(99) < k_out_pct);
    flush     = f_flush || ($urandom_range(99) < k_flush_pct);
    flush_pc  = f_flush ? f_flush_pc : rand_addr();
    f_flush   = 1'b0;
    if (f_dnpc_en) dnpc = f_dnpc;
    else if (cur_pc[1:0] != 2'b00 || $urandom_range(99) < k_jump_pct) dnpc = rand_addr();
    else dnpc = cur_pc + 32'd4;

    // response channel
    rsp_fire = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    bus.imem_rsp_err   = $urandom_range(1) == 1;
    if (pending) begin
      if (mem_delay == 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_data(mem_addr);
        bus.imem_rsp_err   = mem_err(mem_addr);
        rsp_fire = bus.imem_rsp_ready;
      end else begin
        mem_delay--;
      end
    end else if (!bus.imem_rsp_ready && (late_cnt > 0 || $urandom_range(7) == 0)) begin
      // stale or spurious response the fetch unit must ignore
      if (late_cnt > 0) late_cnt--;
      bus.imem_rsp_valid = 1'b1;
    end

    // request channel
    bus.imem_req_ready = ($urandom_range(99) < k_req_pct);
    if (bus.imem_req_valid) begin
      check("req_addr", bus.imem_req_addr, cur_pc);
      check("req_aligned", bus.imem_req_addr[1:0], 2'b00);
      check("one_outstanding", pending, 1'b0);
      if (bus.imem_req_ready && !pending) begin
        pending   = 1'b1;
        mem_addr  = bus.imem_req_addr;
        mem_delay = (k_lat < 0) ? $urandom_range(3) : k_lat;
      end
    end
    if (rsp_fire) pending = 1'b0;

    // architectural fetch sequence
    if (out_valid && out_ready && !flush) begin
      cur_pc    = dnpc;
      f_dnpc_en = 1'b0;
      q.push_back(expect_for(dnpc));
    end
    if (flush) begin
      q.delete();
      cur_pc = flush_pc;
      q.push_back(expect_for(flush_pc));
    end
  endtask

  // Monitor: compares every delivered instruction and output stability
  logic        prev_hold = 1'b0;
  logic [64:0] prev_val = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (prev_hold)
        check("hold_stable", {out_valid, out_pc, out_inst, fetch_err}, {1'b1, prev_val});
      if (out_valid && out_ready && !flush) begin
        fires++;
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL deliver_unexpected: got pc %0h with no fetch pending", out_pc);
        end else begin
          e = q.pop_front();
          check("deliver", {out_pc, out_inst, fetch_err}, {e.pc, e.inst, e.err});
        end
      end
      prev_hold = out_valid && !out_ready && !flush;
      prev_val  = {out_pc, out_inst, fetch_err};
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    logic [64:0] held;
    int          reqs, last_fires, idle;
    logic        saw_out;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_err   = 1'b0;
    model_reset();
    late_cnt = 0;

    // reset and first request
    tick(); step(); tick();
    check("reset_out", {out_valid, bus.imem_req_valid, bus.imem_rsp_ready, out_inst, out_pc, fetch_err}, '0);
    rst = 1'b1;
    step();
    tick();
    check("first_req", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, RESET_PC});

    // back-to-back with 1-cycle memory
    step(); tick();
    check("wait_state", {out_valid, bus.imem_rsp_ready}, 2'b01);
    step(); tick();
    check("first_out", {out_valid, out_inst, out_pc, fetch_err}, {1'b1, 32'h0010_0093, RESET_PC, 1'b0});
    step(); tick();
    check("second_req", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h8000_0004});
    step(); tick(); step(); tick();
    check("throughput", {out_valid, out_pc}, {1'b1, 32'h8000_0004});

    // backpressure
    k_out_pct = 0;
    for (int i = 0; i < 20 && !out_valid; i++) begin step(); tick(); end
    check("bp_reach", out_valid, 1'b1);
    held = {out_pc, out_inst, fetch_err};
    for (int i = 0; i < 5; i++) begin
      step(); tick();
      check("bp_hold", {out_valid, bus.imem_req_valid, out_pc, out_inst, fetch_err}, {2'b10, held});
    end
    k_out_pct = 100;

    // flush while waiting on a slow response
    k_lat = 3;
    for (int i = 0; i < 20 && !bus.imem_rsp_ready; i++) begin step(); tick(); end
    check("flush_reach_wait", bus.imem_rsp_ready, 1'b1);
    f_flush = 1'b1;
    f_flush_pc = 32'h8000_0100;
    step();
    saw_out = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.imem_req_valid) break;
      saw_out |= out_valid;
      step();
    end
    check("flush_no_out", saw_out, 1'b0);
    check("flush_req", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h8000_0100});
    k_lat = 0;

    // misaligned dnpc, then a bus error
    f_dnpc_en = 1'b1;
    f_dnpc = 32'h8000_0002;
    reqs = 0;
    for (int i = 0; i < 30; i++) begin
      step(); tick();
      if (!f_dnpc_en && out_valid) break;
      if (!f_dnpc_en && bus.imem_req_valid) reqs++;
    end
    check("misalign_out", {out_valid, fetch_err, out_inst, out_pc}, {2'b11, 32'h0, 32'h8000_0002});
    check("misalign_noreq", reqs, 0);
    f_dnpc_en = 1'b1;
    f_dnpc = 32'h8000_E000;
    for (int i = 0; i < 30; i++) begin
      step(); tick();
      if (!f_dnpc_en && out_valid) break;
    end
    check("buserr_out", {out_valid, fetch_err, out_pc}, {2'b11, 32'h8000_E000});

    // reset while a response is outstanding
    k_lat = 3;
    for (int i = 0; i < 20 && !bus.imem_rsp_ready; i++) begin step(); tick(); end
    check("rst_reach_wait", bus.imem_rsp_ready, 1'b1);
    rst = 1'b0;
    step(); tick();
    check("rst_mid_wait", {out_valid, bus.imem_req_valid, bus.imem_rsp_ready, out_inst, out_pc, fetch_err}, '0);
    rst = 1'b1;
    step(); tick();
    check("rst_restart", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, RESET_PC});
    for (int i = 0; i < 20 && !out_valid; i++) begin step(); tick(); end
    check("rst_refetch", {out_valid, out_pc, out_inst}, {1'b1, RESET_PC, 32'h0010_0093});

    // randomized traffic
    k_req_pct = 70; k_out_pct = 70; k_flush_pct = 4; k_lat = -1;
    k_jump_pct = 20; k_mis_pct = 8;
    last_fires = fires;
    idle = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = (c != 2000);
      step(); tick();
      if (fires != last_fires || flush) begin
        last_fires = fires;
        idle = 0;
      end else if (++idle > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: no instruction delivered for %0d cycles", idle);
        break;
      end
    end
    check("progress", fires > 300, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
